// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents:
//   - opcode encodings (zero-extended to OPC_W bits so any OP_WIDTH <= OPC_W works)
//   - FSM state encoding
//   - alu_single(): result and flags of every single-cycle operation, computed at
//     ALU_MAX_W bits for a run-time operand width so one function serves every
//     DATA_WIDTH up to ALU_MAX_W
package alu_pkg;

    localparam int ALU_MAX_W = 64;
    localparam int OPC_W     = 16;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_SLL  = 16'b000000;
    localparam opcode_t OP_SRL  = 16'b000010;
    localparam opcode_t OP_SRA  = 16'b000011;
    localparam opcode_t OP_MUL  = 16'b011000;
    localparam opcode_t OP_ADD  = 16'b100000;
    localparam opcode_t OP_SUB  = 16'b100010;
    localparam opcode_t OP_AND  = 16'b100100;
    localparam opcode_t OP_OR   = 16'b100101;
    localparam opcode_t OP_XOR  = 16'b100110;
    localparam opcode_t OP_NOR  = 16'b100111;
    localparam opcode_t OP_SLT  = 16'b101010;
    localparam opcode_t OP_SLTU = 16'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALU_MAX_W-1:0] result;
        logic                 overflow;
        logic                 carry;
        logic                 illegal;
    } alu_out_t;

    // a and b must already be zero-extended from width bits. The sign bit and the
    // carry bit are picked out with masks rather than variable bit indices.
    function automatic alu_out_t alu_single(input logic [ALU_MAX_W-1:0] a,
                                            input logic [ALU_MAX_W-1:0] b,
                                            input opcode_t              op,
                                            input int                   shamt,
                                            input int                   width);
        logic [ALU_MAX_W:0]   one_x;
        logic [ALU_MAX_W:0]   sum_x;
        logic [ALU_MAX_W:0]   carry_mask;
        logic [ALU_MAX_W-1:0] mask;
        logic [ALU_MAX_W-1:0] msb_mask;
        logic [ALU_MAX_W-1:0] sa;
        logic [ALU_MAX_W-1:0] sb;
        logic [ALU_MAX_W-1:0] res;
        logic                 a_neg;
        logic                 b_neg;
        logic                 r_neg;
        alu_out_t             o;

        one_x      = {{ALU_MAX_W{1'b0}}, 1'b1};
        mask       = ALU_MAX_W'((one_x << width) - one_x);
        msb_mask   = ALU_MAX_W'(one_x << (width - 1));
        carry_mask = one_x << width;
        a_neg      = |(a & msb_mask);
        b_neg      = |(b & msb_mask);
        // Sign-extended copies for the signed compare and arithmetic shift.
        sa         = a_neg ? (a | ~mask) : a;
        sb         = b_neg ? (b | ~mask) : b;
        sum_x      = '0;
        res        = '0;
        r_neg      = 1'b0;
        o          = '0;

        case (op)
            OP_ADD: begin
                sum_x      = {1'b0, a} + {1'b0, b};
                res        = sum_x[ALU_MAX_W-1:0] & mask;
                r_neg      = |(res & msb_mask);
                o.carry    = |(sum_x & carry_mask);
                o.overflow = (a_neg == b_neg) && (r_neg != a_neg);
            end
            OP_SUB: begin
                // carry out of A + ~B + 1 means "no borrow"
                sum_x      = {1'b0, a} + {1'b0, ~b & mask} + one_x;
                res        = sum_x[ALU_MAX_W-1:0] & mask;
                r_neg      = |(res & msb_mask);
                o.carry    = |(sum_x & carry_mask);
                o.overflow = (a_neg != b_neg) && (r_neg != a_neg);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b) & mask;
            OP_SLL:  res = (a << shamt) & mask;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = ALU_MAX_W'($signed(sa) >>> shamt) & mask;
            OP_SLT:  res[0] = ($signed(sa) < $signed(sb));
            OP_SLTU: res[0] = (a < b);
            default: o.illegal = 1'b1;
        endcase

        o.result = res;
        return o;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath, one multiplier bit per cycle.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (discards any product)
//   start        load a/b and begin; ignored bits are cleared
//   a, b         multiplicand, multiplier (sampled on start)
//   done         high during the final iteration cycle
//   product      accumulator value after the current iteration; the full
//                product when done is high
module alu_mul_iter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [2*DATA_WIDTH-1:0] mcand_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [2*DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    busy_q;

    always_comb begin
        acc_next = acc_q;
        if (mplier_q[0]) begin
            acc_next = acc_q + (mcand_q << cnt_q);
        end
    end

    assign done    = busy_q && (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign product = acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{DATA_WIDTH{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_next;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a multi-cycle MUL.
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high; valid never depends on ready, and once out_valid is high the
// result and flags hold until the consumer takes them.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid, in_ready         operand/opcode handshake
//   A, B, operation            operands and opcode (sampled only on accept)
//   out_valid, out_ready       result handshake
//   result                     registered result
//   zero, overflow, carry      result flags
//   illegal                    opcode not recognised
//   dbg_state                  current FSM state
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int OP_WIDTH    = 6,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [OP_WIDTH-1:0]   operation,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  overflow,
    output logic                  carry,
    output logic                  illegal,
    output state_t                dbg_state
);

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept;
    logic                    is_mul;
    logic                    load_single;
    logic                    load_mul;
    logic                    start_mul;
    logic                    mul_done;
    logic [2*DATA_WIDTH-1:0] mul_product;
    logic [ALU_MAX_W-1:0]    a_ext;
    logic [ALU_MAX_W-1:0]    b_ext;
    opcode_t                 op_ext;
    alu_out_t                calc;

    always_comb begin
        a_ext                       = '0;
        b_ext                       = '0;
        op_ext                      = '0;
        a_ext[DATA_WIDTH-1:0]       = A;
        b_ext[DATA_WIDTH-1:0]       = B;
        op_ext[OP_WIDTH-1:0]        = operation;
        calc = alu_single(a_ext, b_ext, op_ext, int'(B[SHAMT_WIDTH-1:0]), DATA_WIDTH);
    end

    // Only the low DATA_WIDTH bits of the wide result are meaningful.
    if (DATA_WIDTH < ALU_MAX_W) begin : g_pad
        logic pad_unused;
        assign pad_unused = |calc.result[ALU_MAX_W-1:DATA_WIDTH];
    end

    assign is_mul    = (op_ext == OP_MUL);
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE and DONE share the accept path: in DONE, accept already implies
    // out_ready, so a new operation replaces the result being handed off.
    always_comb begin
        state_d     = state_q;
        load_single = 1'b0;
        load_mul    = 1'b0;
        start_mul   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d   = ST_MUL;
                        start_mul = 1'b1;
                    end else begin
                        state_d     = ST_DONE;
                        load_single = 1'b1;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    load_mul = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            illegal  <= 1'b0;
        end else if (load_single) begin
            result   <= calc.result[DATA_WIDTH-1:0];
            zero     <= (calc.result[DATA_WIDTH-1:0] == '0);
            overflow <= calc.overflow;
            carry    <= calc.carry;
            illegal  <= calc.illegal;
        end else if (load_mul) begin
            result   <= mul_product[DATA_WIDTH-1:0];
            zero     <= (mul_product[DATA_WIDTH-1:0] == '0);
            overflow <= |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
            carry    <= 1'b0;
            illegal  <= 1'b0;
        end
    end

    alu_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start_mul),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the lab's combinational ALU.
- Adds a valid/ready handshake on input and output, carry and illegal-op flags, SLL/SLT/SLTU, and a multi-cycle shift-add MUL.
- Sits between operand registers/datapath control and writeback. Output is held stable under backpressure.

Parameters:
- DATA_WIDTH, 8, operand and result width (>=4).
- OP_WIDTH, 6, opcode width.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), number of low B bits used as shift amount.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept.
- A  in  DATA_WIDTH  operand A.
- B  in  DATA_WIDTH  operand B (shift amount = B[SHAMT_WIDTH-1:0]).
- operation  in  OP_WIDTH  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (ADD/SUB), unsigned high-half nonzero (MUL).
- carry  out  1  carry-out (ADD); no-borrow (SUB); 0 otherwise.
- illegal  out  1  opcode not recognised.

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0, result=0, zero=0, overflow=0, carry=0, illegal=0. Any in-flight MUL is discarded. in_ready=1 from the first cycle after reset deasserts.
- Opcodes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111 keep their existing encodings.
  - SRA 000011 and SRL 000010 keep their existing encodings.
  - SLL 000000, SLT 101010, SLTU 101011 and MUL 011000 are new.
- Handshake:
  - Accept occurs on a cycle with in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Output transfers on a cycle with out_valid && out_ready.
- FSM, IDLE -> DONE: on accept of a single-cycle op, capture result and flags; out_valid=1 the next cycle (latency 1).
- FSM, IDLE -> MUL: on accept of MUL.
  - Load multiplicand A, multiplier B, and a 2*DATA_WIDTH accumulator=0; counter=0.
  - Each cycle in MUL: if multiplier[0], accumulator += multiplicand<<counter; multiplier>>=1; counter++.
  - After DATA_WIDTH iterations -> DONE. out_valid rises exactly DATA_WIDTH+1 cycles after the accept cycle.
  - in_ready=0 throughout MUL.
- FSM, DONE:
  - out_valid=1; result and flags stable while out_ready=0.
  - On out_ready with no new accept -> IDLE, out_valid=0 next cycle.
  - On out_ready with a simultaneous accept -> back-to-back: single-cycle op stays DONE with the new result; MUL -> MUL with out_valid=0.
- Arithmetic (all ops wrap modulo 2^DATA_WIDTH):
  - ADD {carry,result}=A+B.
  - SUB {carry,result}=A+~B+1.
  - SRA arithmetic right shift of signed A; SRL logical right; SLL logical left. All shift by B[SHAMT_WIDTH-1:0]; upper B bits are ignored.
  - SLT result = ($signed(A)<$signed(B)) zero-extended; SLTU same, unsigned compare.
  - MUL result = product[DATA_WIDTH-1:0]; overflow = |product[2*DATA_WIDTH-1:DATA_WIDTH].
- Flags:
  - ADD overflow = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
  - SUB overflow = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
  - overflow is 0 for all ops other than ADD, SUB and MUL.
  - zero computed from the registered result for all ops.
- Illegal opcode: result=0, zero=1, illegal=1, other flags 0. Handled as a normal single-cycle transaction.
- Operands and opcode are sampled only on accept; changes while in_ready=0 are ignored.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ADD..MUL);
  - FSM state encoding (IDLE, MUL, DONE);
  - a function computing single-cycle result/flags from (A, B, operation).
- One sub-module: alu_mul_iter, the shift-add multiplier datapath (start, done, product), instantiated by alu_seq.

Test Plan:
- DATA_WIDTH=8. ADD A=0x7F B=0x01, out_ready=1 -> next cycle out_valid=1, result=0x80, overflow=1, carry=0, zero=0.
- SUB A=0x05 B=0x05 -> result=0x00, zero=1, carry=1, overflow=0. SLT A=0x80 B=0x01 -> result=0x01. SLTU same operands -> result=0x00.
- SRA A=0x80 B=0x0B (shamt 3) -> 0xF0. SRL same -> 0x10. SLL A=0x81 B=0x01 -> 0x02.
- MUL A=0x10 B=0x10 -> in_ready=0 for 8 cycles; out_valid exactly 9 cycles after accept; result=0x00, overflow=1. MUL 0x0F*0x0F -> 0xE1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 0x12+0x34 -> result=0x46 stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0xFF,0x0F) -> next cycle result=0xF0, out_valid=1 (back-to-back).
- Reset asserted mid-MUL (cycle 4) -> out_valid=0 immediately, all outputs 0. After release, in_ready=1 and a new ADD completes normally. Illegal op 0x3F -> result=0, illegal=1, zero=1.
